naive_bus_rr_arbiter: RTL and testbench



---
 rtl/naive_bus_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_naive_bus_rr_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin arbiter sharing one naive_bus slave port between N_MASTER
// masters. Selection is combinational and sticky until the selected
// master's request is granted; read data is steered back one cycle later
// using a one-hot ownership register.

// Per-master return path: grant steering and read-data gating.
module naive_bus_rr_arbiter_lane (
  input  logic        rst,
  input  logic        sel_hit,
  input  logic        rd_hit,
  input  logic        wr_hit,
  input  logic        rd_own,
  input  logic [31:0] s_rd_data,
  output logic        rd_gnt,
  output logic        wr_gnt,
  output logic [31:0] rd_data
);

  assign rd_gnt  = sel_hit & rd_hit;
  assign wr_gnt  = sel_hit & wr_hit;
  // data of a read granted just before reset must not leak out during reset
  assign rd_data = (rd_own & ~rst) ? s_rd_data : '0;

endmodule

module naive_bus_rr_arbiter #(
  parameter int N_MASTER = 3,
  parameter int RD_PRIO  = 1,
  localparam int OW      = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTER-1:0]          m_rd_req,
  input  logic [N_MASTER-1:0][3:0]     m_rd_be,
  input  logic [N_MASTER-1:0][31:0]    m_rd_addr,
  output logic [N_MASTER-1:0][31:0]    m_rd_data,
  output logic [N_MASTER-1:0]          m_rd_gnt,
  input  logic [N_MASTER-1:0]          m_wr_req,
  input  logic [N_MASTER-1:0][3:0]     m_wr_be,
  input  logic [N_MASTER-1:0][31:0]    m_wr_addr,
  input  logic [N_MASTER-1:0][31:0]    m_wr_data,
  output logic [N_MASTER-1:0]          m_wr_gnt,
  output logic                         s_rd_req,
  output logic [3:0]                   s_rd_be,
  output logic [31:0]                  s_rd_addr,
  input  logic [31:0]                  s_rd_data,
  input  logic                         s_rd_gnt,
  output logic                         s_wr_req,
  output logic [3:0]                   s_wr_be,
  output logic [31:0]                  s_wr_addr,
  output logic [31:0]                  s_wr_data,
  input  logic                         s_wr_gnt,
  output logic [OW-1:0]                owner,
  output logic                         busy
);

  typedef struct packed {
    logic        req;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic [OW-1:0]       ptr;
  logic [N_MASTER-1:0] rd_owner;
  logic [N_MASTER-1:0] active;
  logic [OW-1:0]       sel;
  logic                found;
  logic                fwd_rd;
  logic                rd_hit;
  logic                wr_hit;
  req_t                rd_fwd;
  req_t                wr_fwd;

  assign active = m_rd_req | m_wr_req;
  assign busy   = |active;
  assign owner  = sel;

  // Rotating scan starting at ptr; falls back to ptr when nobody requests.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_MASTER; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_MASTER) j = j - N_MASTER;
      if (!found && active[j]) begin
        found = 1'b1;
        sel   = OW'(j);
      end
    end
  end

  // Pick read or write of the selected master and build the slave request.
  always_comb begin
    rd_fwd = '0;
    wr_fwd = '0;
    fwd_rd = found & m_rd_req[sel] & ((RD_PRIO != 0) | ~m_wr_req[sel]);
    if (!rst && found) begin
      if (fwd_rd) begin
        rd_fwd.req  = 1'b1;
        rd_fwd.be   = m_rd_be[sel];
        rd_fwd.addr = m_rd_addr[sel];
      end else begin
        wr_fwd.req  = 1'b1;
        wr_fwd.be   = m_wr_be[sel];
        wr_fwd.addr = m_wr_addr[sel];
        wr_fwd.data = m_wr_data[sel];
      end
    end
  end

  assign s_rd_req  = rd_fwd.req;
  assign s_rd_be   = rd_fwd.be;
  assign s_rd_addr = rd_fwd.addr;
  assign s_wr_req  = wr_fwd.req;
  assign s_wr_be   = wr_fwd.be;
  assign s_wr_addr = wr_fwd.addr;
  assign s_wr_data = wr_fwd.data;

  // a slave grant only counts against the request actually forwarded
  assign rd_hit = s_rd_gnt & s_rd_req;
  assign wr_hit = s_wr_gnt & s_wr_req;

  // Advance priority past a granted master; remember who owns the next rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      rd_owner <= '0;
    end else begin
      if (rd_hit | wr_hit)
        ptr <= (sel == OW'(N_MASTER - 1)) ? '0 : sel + OW'(1);
      rd_owner <= rd_hit ? (N_MASTER'(1) << sel) : '0;
    end
  end

  for (genvar i = 0; i < N_MASTER; i++) begin : g_lane
    naive_bus_rr_arbiter_lane u_lane (
      .rst       (rst),
      .sel_hit   (sel == OW'(i)),
      .rd_hit    (rd_hit),
      .wr_hit    (wr_hit),
      .rd_own    (rd_owner[i]),
      .s_rd_data (s_rd_data),
      .rd_gnt    (m_rd_gnt[i]),
      .wr_gnt    (m_wr_gnt[i]),
      .rd_data   (m_rd_data[i])
    );
  end

endmodule

// File: tb/tb_naive_bus_rr_arbiter.sv
// Directed bench for naive_bus_rr_arbiter (3 masters, read priority).
module tb_naive_bus_rr_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        m_rd_req, m_wr_req, m_rd_gnt, m_wr_gnt;
  logic [2:0][3:0]   m_rd_be, m_wr_be;
  logic [2:0][31:0]  m_rd_addr, m_rd_data, m_wr_addr, m_wr_data;
  logic              s_rd_req, s_rd_gnt, s_wr_req, s_wr_gnt;
  logic [3:0]        s_rd_be, s_wr_be;
  logic [31:0]       s_rd_addr, s_rd_data, s_wr_addr, s_wr_data;
  logic [1:0]        owner;
  logic              busy;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  naive_bus_rr_arbiter #(.N_MASTER(3), .RD_PRIO(1)) dut (
    .clk(clk), .rst(rst),
    .m_rd_req(m_rd_req), .m_rd_be(m_rd_be), .m_rd_addr(m_rd_addr),
    .m_rd_data(m_rd_data), .m_rd_gnt(m_rd_gnt),
    .m_wr_req(m_wr_req), .m_wr_be(m_wr_be), .m_wr_addr(m_wr_addr),
    .m_wr_data(m_wr_data), .m_wr_gnt(m_wr_gnt),
    .s_rd_req(s_rd_req), .s_rd_be(s_rd_be), .s_rd_addr(s_rd_addr),
    .s_rd_data(s_rd_data), .s_rd_gnt(s_rd_gnt),
    .s_wr_req(s_wr_req), .s_wr_be(s_wr_be), .s_wr_addr(s_wr_addr),
    .s_wr_data(s_wr_data), .s_wr_gnt(s_wr_gnt),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    bit        rst;
    bit [2:0]  rd, wr;
    bit        srg, swg;
    bit [31:0] sdat;
    bit        e_srq, e_swq;
    bit [31:0] e_raddr, e_waddr, e_wdata;
    bit [2:0]  e_rgnt, e_wgnt;
    bit [1:0]  e_own;
    bit        e_busy;
    bit [31:0] e_d0, e_d1, e_d2;
  } vec_t;

  vec_t tv[22];

  task automatic chk(input string name, input int row, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    // fixed per-master request payloads
    for (int i = 0; i < 3; i++) begin
      m_rd_addr[i] = 32'h20000 + 32'(4 * i);
      m_rd_be[i]   = 4'(i + 1);
      m_wr_be[i]   = 4'hF;
    end
    m_wr_addr[0] = 32'h20020; m_wr_data[0] = 32'h11110000;
    m_wr_addr[1] = 32'h20010; m_wr_data[1] = 32'hDEADBEEF;
    m_wr_addr[2] = 32'h20018; m_wr_data[2] = 32'h22220000;

    //         rst rd     wr     srg swg sdat          srq swq raddr         waddr         wdata          rgnt    wgnt    own bsy d0            d1            d2
    tv[0]  = '{1, 3'b000,3'b000,0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,         3'b000, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0};
    tv[1]  = '{0, 3'b000,3'b000,1, 1, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,         3'b000, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0};
    tv[2]  = '{0, 3'b000,3'b000,0, 0, 32'h55,       0, 0, 32'h0,        32'h0,        32'h0,         3'b000, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0};
    tv[3]  = '{0, 3'b111,3'b000,1, 0, 32'h0,        1, 0, 32'h20000,    32'h0,        32'h0,         3'b001, 3'b000, 0, 1, 32'h0,        32'h0,        32'h0};
    tv[4]  = '{0, 3'b111,3'b000,1, 0, 32'h20001,    1, 0, 32'h20004,    32'h0,        32'h0,         3'b010, 3'b000, 1, 1, 32'h20001,    32'h0,        32'h0};
    tv[5]  = '{0, 3'b111,3'b000,1, 0, 32'h20005,    1, 0, 32'h20008,    32'h0,        32'h0,         3'b100, 3'b000, 2, 1, 32'h0,        32'h20005,    32'h0};
    tv[6]  = '{0, 3'b111,3'b000,1, 0, 32'h20009,    1, 0, 32'h20000,    32'h0,        32'h0,         3'b001, 3'b000, 0, 1, 32'h0,        32'h0,        32'h20009};
    tv[7]  = '{0, 3'b000,3'b000,0, 0, 32'h20001,    0, 0, 32'h0,        32'h0,        32'h0,         3'b000, 3'b000, 1, 0, 32'h20001,    32'h0,        32'h0};
    tv[8]  = '{0, 3'b000,3'b110,0, 0, 32'h0,        0, 1, 32'h0,        32'h20010,    32'hDEADBEEF,  3'b000, 3'b000, 1, 1, 32'h0,        32'h0,        32'h0};
    tv[9]  = tv[8];
    tv[10] = tv[8];
    tv[11] = '{0, 3'b000,3'b110,0, 1, 32'h0,        0, 1, 32'h0,        32'h20010,    32'hDEADBEEF,  3'b000, 3'b010, 1, 1, 32'h0,        32'h0,        32'h0};
    tv[12] = '{0, 3'b000,3'b100,0, 1, 32'h0,        0, 1, 32'h0,        32'h20018,    32'h22220000,  3'b000, 3'b100, 2, 1, 32'h0,        32'h0,        32'h0};
    tv[13] = '{0, 3'b000,3'b000,1, 1, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,         3'b000, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0};
    tv[14] = '{0, 3'b001,3'b001,1, 1, 32'h0,        1, 0, 32'h20000,    32'h0,        32'h0,         3'b001, 3'b000, 0, 1, 32'h0,        32'h0,        32'h0};
    tv[15] = '{0, 3'b000,3'b001,1, 1, 32'hAAAA,     0, 1, 32'h0,        32'h20020,    32'h11110000,  3'b000, 3'b001, 0, 1, 32'hAAAA,     32'h0,        32'h0};
    tv[16] = '{0, 3'b100,3'b000,1, 0, 32'h0,        1, 0, 32'h20008,    32'h0,        32'h0,         3'b100, 3'b000, 2, 1, 32'h0,        32'h0,        32'h0};
    tv[17] = '{1, 3'b100,3'b000,1, 0, 32'hBBBB,     0, 0, 32'h0,        32'h0,        32'h0,         3'b000, 3'b000, 2, 1, 32'h0,        32'h0,        32'h0};
    tv[18] = '{0, 3'b000,3'b000,0, 0, 32'hBBBB,     0, 0, 32'h0,        32'h0,        32'h0,         3'b000, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0};
    tv[19] = '{0, 3'b010,3'b000,1, 0, 32'h0,        1, 0, 32'h20004,    32'h0,        32'h0,         3'b010, 3'b000, 1, 1, 32'h0,        32'h0,        32'h0};
    tv[20] = '{1, 3'b000,3'b000,0, 0, 32'hCCCC,     0, 0, 32'h0,        32'h0,        32'h0,         3'b000, 3'b000, 2, 0, 32'h0,        32'h0,        32'h0};
    tv[21] = '{0, 3'b000,3'b000,0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,         3'b000, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0};

    rst = 1'b1; m_rd_req = '0; m_wr_req = '0;
    s_rd_gnt = 1'b0; s_wr_gnt = 1'b0; s_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < 22; r++) begin
      rst = tv[r].rst; m_rd_req = tv[r].rd; m_wr_req = tv[r].wr;
      s_rd_gnt = tv[r].srg; s_wr_gnt = tv[r].swg; s_rd_data = tv[r].sdat;
      @(negedge clk);
      chk("s_rd_req",  r, 96'(s_rd_req),  96'(tv[r].e_srq));
      chk("s_wr_req",  r, 96'(s_wr_req),  96'(tv[r].e_swq));
      chk("s_rd_addr", r, 96'(s_rd_addr), 96'(tv[r].e_raddr));
      chk("s_wr_addr", r, 96'(s_wr_addr), 96'(tv[r].e_waddr));
      chk("s_wr_data", r, 96'(s_wr_data), 96'(tv[r].e_wdata));
      chk("m_rd_gnt",  r, 96'(m_rd_gnt),  96'(tv[r].e_rgnt));
      chk("m_wr_gnt",  r, 96'(m_wr_gnt),  96'(tv[r].e_wgnt));
      chk("owner",     r, 96'(owner),     96'(tv[r].e_own));
      chk("busy",      r, 96'(busy),      96'(tv[r].e_busy));
      chk("m_rd_data", r, m_rd_data, {tv[r].e_d2, tv[r].e_d1, tv[r].e_d0});
      chk("rd_wr_excl", r, 96'(s_rd_req & s_wr_req), 96'(0));
      @(posedge clk); #1;
    end

    // Fairness: all three writing, slave always grants -> 0,1,2,0,1,2,...
    m_rd_req = '0; m_wr_req = 3'b111; s_wr_gnt = 1'b1; s_rd_gnt = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("fair_wgnt",  100 + k, 96'(m_wr_gnt), 96'(3'b001 << (k % 3)));
      chk("fair_owner", 100 + k, 96'(owner),    96'(k % 3));
      @(posedge clk); #1;
    end

    // Sticky: master 0 read stalled while master 1 waits; switch only when 0 drops.
    m_wr_req = '0; s_wr_gnt = 1'b0; m_rd_req = 3'b011; s_rd_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sticky_addr", 200 + k, 96'(s_rd_addr), 96'(32'h20000));
      chk("sticky_gnt",  200 + k, 96'(m_rd_gnt),  96'(0));
      @(posedge clk); #1;
    end
    m_rd_req = 3'b010; s_rd_gnt = 1'b1;
    @(negedge clk);
    chk("switch_addr", 210, 96'(s_rd_addr), 96'(32'h20004));
    chk("switch_gnt",  210, 96'(m_rd_gnt),  96'(3'b010));
    chk("switch_be",   210, 96'(s_rd_be),   96'(4'h2));
    @(posedge clk); #1;
    m_rd_req = '0; s_rd_gnt = 1'b0; s_rd_data = 32'h1234;
    @(negedge clk);
    chk("switch_data", 211, m_rd_data, {32'h0, 32'h1234, 32'h0});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
